// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - timed three-motor paint dispense sequencer
//
// Runs the red, yellow and blue pumps one after another, each for a time
// proportional to its latched keypad digit. Reports phase, busy and done.
// Optional macro SETTLE_GAP_EN inserts a motor-off settle gap after the
// red and yellow phases.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-low reset
//   start    level; begins a dispense cycle when idle
//   abort    level; returns to idle at the next edge
//   dig_r/y/b  colour amounts (values above MAX_DIGIT count as 0)
//   motores  motor enables [2]=R [1]=Y [0]=B, one-hot or zero
//   fase     0 idle, 1 R, 2 Y, 3 B (a gap shows the preceding phase)
//   busy     high while not idle
//   done     one-cycle pulse on normal completion
module dispense_sequencer #(
  parameter int DIGIT_W        = 5,
  parameter int MAX_DIGIT      = 9,
  parameter int TICK_DIV       = 50000,
  parameter int TICKS_PER_UNIT = 100,
  parameter int GAP_TICKS      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIGIT_W-1:0] dig_r,
  input  logic [DIGIT_W-1:0] dig_y,
  input  logic [DIGIT_W-1:0] dig_b,
  output logic [2:0]         motores,
  output logic [1:0]         fase,
  output logic               busy,
  output logic               done
);

  localparam int TW = $clog2(MAX_DIGIT*TICKS_PER_UNIT+1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV-1);
  localparam logic [TW-1:0] GAP_TARGET = TW'(GAP_TICKS);

`ifdef SETTLE_GAP_EN
  typedef enum logic [2:0] {IDLE, RUN_R, RUN_Y, RUN_B, GAP_RY, GAP_YB} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN_R, RUN_Y, RUN_B} state_e;
`endif

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] amt_r_q, amt_r_d, amt_y_q, amt_y_d, amt_b_q, amt_b_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [2:0]         motores_q, motores_d;
  logic [1:0]         fase_q, fase_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [TW-1:0]      target;
  logic               phase_end;

  function automatic logic [DIGIT_W-1:0] clamp(input logic [DIGIT_W-1:0] d);
    return (32'(d) > MAX_DIGIT) ? '0 : d;
  endfunction

  // Length of the current state in ticks; IDLE falls into the gap arm,
  // where the value is never used.
  always_comb begin
    target = GAP_TARGET;
    case (state_q)
      RUN_R:   target = TW'(32'(amt_r_q) * TICKS_PER_UNIT);
      RUN_Y:   target = TW'(32'(amt_y_q) * TICKS_PER_UNIT);
      RUN_B:   target = TW'(32'(amt_b_q) * TICKS_PER_UNIT);
      default: target = GAP_TARGET;
    endcase
  end

  // A zero-length phase still occupies exactly one cycle.
  assign phase_end = (target == '0) ||
                     ((presc_q == PRESC_LAST) && (tick_q == target - TW'(1)));

  always_comb begin
    state_d = state_q;
    amt_r_d = amt_r_q;
    amt_y_d = amt_y_q;
    amt_b_d = amt_b_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          amt_r_d = clamp(dig_r);
          amt_y_d = clamp(dig_y);
          amt_b_d = clamp(dig_b);
          state_d = RUN_R;
        end
      end
`ifdef SETTLE_GAP_EN
      RUN_R:  if (abort) state_d = IDLE; else if (phase_end) state_d = GAP_RY;
      GAP_RY: if (abort) state_d = IDLE; else if (phase_end) state_d = RUN_Y;
      RUN_Y:  if (abort) state_d = IDLE; else if (phase_end) state_d = GAP_YB;
      GAP_YB: if (abort) state_d = IDLE; else if (phase_end) state_d = RUN_B;
`else
      RUN_R:  if (abort) state_d = IDLE; else if (phase_end) state_d = RUN_Y;
      RUN_Y:  if (abort) state_d = IDLE; else if (phase_end) state_d = RUN_B;
`endif
      RUN_B: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every transition changes state, so any change means entry into a new
    // timed state and both counters restart from zero.
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = tick_q + TW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
      tick_d  = tick_q;
    end
    if ((state_d != state_q) || (state_d == IDLE)) begin
      presc_d = '0;
      tick_d  = '0;
    end

    // Outputs are decoded from the next state so they register with it.
    motores_d = 3'b000;
    fase_d    = 2'd0;
    case (state_d)
      RUN_R:  begin motores_d = {(amt_r_d != '0), 2'b00}; fase_d = 2'd1; end
      RUN_Y:  begin motores_d = {1'b0, (amt_y_d != '0), 1'b0}; fase_d = 2'd2; end
      RUN_B:  begin motores_d = {2'b00, (amt_b_d != '0)}; fase_d = 2'd3; end
`ifdef SETTLE_GAP_EN
      GAP_RY: fase_d = 2'd1;
      GAP_YB: fase_d = 2'd2;
`endif
      default: begin
        motores_d = 3'b000;
        fase_d    = 2'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      amt_r_q   <= '0;
      amt_y_q   <= '0;
      amt_b_q   <= '0;
      presc_q   <= '0;
      tick_q    <= '0;
      motores_q <= 3'b000;
      fase_q    <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      amt_r_q   <= amt_r_d;
      amt_y_q   <= amt_y_d;
      amt_b_q   <= amt_b_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      motores_q <= motores_d;
      fase_q    <= fase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign motores = motores_q;
  assign fase    = fase_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - table-driven bench for dispense_sequencer
module tb_dispense_sequencer;

`ifdef SETTLE_GAP_EN
  localparam int G = 4;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] dig_r = '0, dig_y = '0, dig_b = '0;
  logic [2:0] motores;
  logic [1:0] fase;
  logic       busy, done;

  dispense_sequencer #(
    .DIGIT_W(5), .MAX_DIGIT(9), .TICK_DIV(4), .TICKS_PER_UNIT(2), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dig_r(dig_r), .dig_y(dig_y), .dig_b(dig_b),
    .motores(motores), .fase(fase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, abort;
    logic [4:0] r, y, b;
    int         n;
    logic [2:0] mot;
    logic [1:0] fase;
    logic       busy, done;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic add(input logic rs, input logic st, input logic ab,
                     input logic [4:0] r, input logic [4:0] y, input logic [4:0] b,
                     input int n, input logic [2:0] mot, input logic [1:0] fs,
                     input logic bs, input logic dn);
    vec_t v;
    v.rst = rs; v.start = st; v.abort = ab; v.r = r; v.y = y; v.b = b;
    v.n = n; v.mot = mot; v.fase = fs; v.busy = bs; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rs, input logic st, input logic ab,
                      input logic [4:0] r, input logic [4:0] y, input logic [4:0] b);
    rst = rs; start = st; abort = ab; dig_r = r; dig_y = y; dig_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  initial begin
    // test 1: reset then r=3 y=1 b=2; digits changed while busy
    add(0,0,0, 0,0,0,  2, 3'b000,0,0,0);
    add(1,0,0, 0,0,0,  1, 3'b000,0,0,0);
    add(1,1,0, 3,1,2,  1, 3'b100,1,1,0);
    add(1,0,0, 9,9,9, 23, 3'b100,1,1,0);
    add(1,0,0, 9,9,9,  G, 3'b000,1,1,0);
    add(1,0,0, 9,9,9,  8, 3'b010,2,1,0);
    add(1,0,0, 9,9,9,  G, 3'b000,2,1,0);
    add(1,0,0, 9,9,9, 16, 3'b001,3,1,0);
    add(1,0,0, 9,9,9,  1, 3'b000,0,0,1);
    add(1,0,0, 9,9,9,  2, 3'b000,0,0,0);
    // test 2: zero and clamped (17) amounts
    add(1,1,0, 0,2,17, 1, 3'b000,1,1,0);
    add(1,0,0, 0,0,0,  G, 3'b000,1,1,0);
    add(1,0,0, 0,0,0, 16, 3'b010,2,1,0);
    add(1,0,0, 0,0,0,  G, 3'b000,2,1,0);
    add(1,0,0, 0,0,0,  1, 3'b000,3,1,0);
    add(1,0,0, 0,0,0,  1, 3'b000,0,0,1);
    add(1,0,0, 0,0,0,  1, 3'b000,0,0,0);
    // test 3: abort 5 cycles into RUN_Y, no done, then restart at RUN_R
    add(1,1,0, 1,2,1,  1, 3'b100,1,1,0);
    add(1,0,0, 1,2,1,  7, 3'b100,1,1,0);
    add(1,0,0, 1,2,1,  G, 3'b000,1,1,0);
    add(1,0,0, 1,2,1,  5, 3'b010,2,1,0);
    add(1,0,1, 1,2,1,  1, 3'b000,0,0,0);
    add(1,0,0, 1,2,1,  2, 3'b000,0,0,0);
    add(1,1,0, 1,2,1,  1, 3'b100,1,1,0);
    add(1,0,0, 1,2,1,  7, 3'b100,1,1,0);
    add(1,0,0, 1,2,1,  G, 3'b000,1,1,0);
    add(1,0,0, 1,2,1, 16, 3'b010,2,1,0);
    add(1,0,0, 1,2,1,  G, 3'b000,2,1,0);
    add(1,0,0, 1,2,1,  3, 3'b001,3,1,0);
    // test 5: reset mid-RUN_B, then abort+start in idle
    add(0,0,0, 1,2,1,  1, 3'b000,0,0,0);
    add(1,0,0, 1,2,1,  2, 3'b000,0,0,0);
    add(1,1,1, 1,1,1,  3, 3'b000,0,0,0);
    add(1,0,0, 1,1,1,  1, 3'b000,0,0,0);
    // test 4 (and gap pattern of test 6): start held through and after done
    add(1,1,0, 1,1,1,  1, 3'b100,1,1,0);
    add(1,1,0, 2,0,1,  7, 3'b100,1,1,0);
    add(1,1,0, 2,0,1,  G, 3'b000,1,1,0);
    add(1,1,0, 2,0,1,  8, 3'b010,2,1,0);
    add(1,1,0, 2,0,1,  G, 3'b000,2,1,0);
    add(1,1,0, 2,0,1,  8, 3'b001,3,1,0);
    add(1,1,0, 2,0,1,  1, 3'b000,0,0,1);
    add(1,1,0, 2,0,1,  1, 3'b100,1,1,0);
    add(1,1,0, 2,0,1,  2, 3'b100,1,1,0);
    add(1,0,0, 2,0,1, 13, 3'b100,1,1,0);
    add(1,0,0, 2,0,1,  G, 3'b000,1,1,0);
    add(1,0,0, 2,0,1,  1, 3'b000,2,1,0);
    add(1,0,0, 2,0,1,  G, 3'b000,2,1,0);
    add(1,0,0, 2,0,1,  8, 3'b001,3,1,0);
    add(1,0,0, 2,0,1,  1, 3'b000,0,0,1);
    add(1,0,0, 2,0,1,  1, 3'b000,0,0,0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].r, vecs[i].y, vecs[i].b);
        check($sformatf("row%0d_cyc%0d_{mot,fase,busy,done}", i, k),
              int'({motores, fase, busy, done}),
              int'({vecs[i].mot, vecs[i].fase, vecs[i].busy, vecs[i].done}));
      end
    end

    // Hand-written: largest amount (9 -> 72 cycles), y=10 clamps to 0, b=0.
    begin
      int cnt;
      int k;
      step(1,1,0, 9,10,0);
      cnt = 0;
      while (motores == 3'b100 && cnt < 200) begin
        cnt++;
        step(1,0,0, 0,0,0);
      end
      check("max_digit_r_cycles", cnt, 72);
      k = 0;
      while (!done && k < 50) begin
        step(1,0,0, 0,0,0);
        k++;
      end
      check("zero_yb_cycles_to_done", k, 2*G + 2);
      step(1,0,0, 0,0,0);
      check("idle_after_done", int'({motores, fase, busy, done}), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
